// File: rtl/sal_axi_rd_traffic_gen.sv
// sal_axi_rd_traffic_gen
//   AXI read-traffic generator. It issues a programmed run of strided INCR
//   bursts on the AR channel and keeps a bounded number of bursts
//   outstanding. It consumes the R channel, checks framing, ID order and
//   response codes, and accumulates beat/error counts and an XOR signature.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               single-cycle start pulse (ignored while busy)
//   start_addr, stride  address of burst 0 and the increment between bursts
//   num_req, len_cfg    number of bursts and ARLEN (beats-1) for each burst
//   ar*                 AXI read-address channel (master side)
//   r*                  AXI read-data channel (master side)
//   busy, done          sequence running / sticky completion flag
//   beat_cnt, err_cnt   accepted R beats / erroneous beats (saturating)
//   rdata_xor           XOR of every accepted rdata word
module sal_axi_rd_traffic_gen #(
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [15:0]           num_req,
  input  logic [3:0]            len_cfg,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [3:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           beat_cnt,
  output logic [15:0]           err_cnt,
  output logic [DATA_WIDTH-1:0] rdata_xor
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [3:0]          MAX_OUT = 4'(MAX_OUTSTANDING);
  localparam logic [2:0]          ARSIZE  = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [ID_WIDTH-1:0] ID_ONE  = ID_WIDTH'(1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [15:0]           num_req_q;
  logic [15:0]           issued;
  logic [3:0]            len_q;
  logic [ID_WIDTH-1:0]   arid_q;
  logic [ID_WIDTH-1:0]   exp_id;
  logic [3:0]            outstanding;
  logic [7:0]            beat_idx;

  logic ar_hs;
  logic r_hs;
  logic r_done;
  logic beat_err;
  logic out_inc;
  logic out_dec;

  // The address/ID registers always hold the request currently being
  // offered, so the AR payload is stable for as long as arvalid waits.
  assign arvalid = (state == ST_ISSUE) && (issued < num_req_q) &&
                   (outstanding < MAX_OUT);
  assign araddr  = araddr_q;
  assign arid    = arid_q;
  assign arlen   = len_q;
  assign arsize  = ARSIZE;
  assign arburst = 2'b01;
  assign rready  = (state != ST_IDLE);
  assign busy    = (state != ST_IDLE);

  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign r_done = r_hs && rlast;

  // Responses must return in issue order, so the expected ID is simply a
  // count of completed bursts. Several faults on one beat count once.
  assign beat_err = (rresp != 2'b00) || (rid != exp_id) ||
                    (rlast != (beat_idx == {4'b0000, len_q}));

  assign out_inc = ar_hs;
  assign out_dec = r_done && (outstanding != 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      stride_q    <= '0;
      araddr_q    <= '0;
      num_req_q   <= '0;
      issued      <= '0;
      len_q       <= '0;
      arid_q      <= '0;
      exp_id      <= '0;
      outstanding <= '0;
      beat_idx    <= '0;
      done        <= 1'b0;
      beat_cnt    <= '0;
      err_cnt     <= '0;
      rdata_xor   <= '0;
    end else begin
      if (r_hs) begin
        beat_cnt  <= beat_cnt + 32'd1;
        rdata_xor <= rdata_xor ^ rdata;
        if (beat_err && (err_cnt != 16'hFFFF)) begin
          err_cnt <= err_cnt + 16'd1;
        end
        if (rlast) begin
          beat_idx <= '0;
          exp_id   <= exp_id + ID_ONE;
        end else if (beat_idx != 8'hFF) begin
          beat_idx <= beat_idx + 8'd1;
        end
      end

      if (ar_hs) begin
        araddr_q <= araddr_q + stride_q;
        arid_q   <= arid_q + ID_ONE;
        issued   <= issued + 16'd1;
      end

      if (out_inc && !out_dec) begin
        outstanding <= outstanding + 4'd1;
      end else if (!out_inc && out_dec) begin
        outstanding <= outstanding - 4'd1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            stride_q    <= stride;
            num_req_q   <= num_req;
            len_q       <= len_cfg;
            araddr_q    <= start_addr;
            arid_q      <= '0;
            issued      <= '0;
            outstanding <= '0;
            exp_id      <= '0;
            beat_idx    <= '0;
            beat_cnt    <= '0;
            err_cnt     <= '0;
            rdata_xor   <= '0;
            if (num_req != 16'd0) begin
              state <= ST_ISSUE;
              done  <= 1'b0;
            end else begin
              done  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (ar_hs && ((issued + 16'd1) == num_req_q)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (outstanding == 4'd0) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sal_axi_rd_traffic_gen.sv
module tb_sal_axi_rd_traffic_gen;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [31:0]  start_addr;
  logic [31:0]  stride;
  logic [15:0]  num_req;
  logic [3:0]   len_cfg;
  logic         arvalid;
  logic         arready;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [3:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rvalid;
  logic         rready;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         busy;
  logic         done;
  logic [31:0]  beat_cnt;
  logic [15:0]  err_cnt;
  logic [127:0] rdata_xor;

  sal_axi_rd_traffic_gen #(
    .ADDR_WIDTH      (32),
    .ID_WIDTH        (4),
    .DATA_WIDTH      (128),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .stride     (stride),
    .num_req    (num_req),
    .len_cfg    (len_cfg),
    .arvalid    (arvalid),
    .arready    (arready),
    .arid       (arid),
    .araddr     (araddr),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .rvalid     (rvalid),
    .rready     (rready),
    .rid        (rid),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .busy       (busy),
    .done       (done),
    .beat_cnt   (beat_cnt),
    .err_cnt    (err_cnt),
    .rdata_xor  (rdata_xor)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Reference totals for the current run
  logic [31:0]  m_beats;
  int unsigned  m_err;
  logic [127:0] m_xor;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    start   = 1'b0;
    arready = 1'b0;
    rvalid  = 1'b0;
    rid     = '0;
    rdata   = '0;
    rresp   = 2'b00;
    rlast   = 1'b0;
  endtask

  // One full sequence. The model knows only the rules: request k goes to
  // sa + k*st with ID k mod 16, at most 4 bursts in flight, responses in
  // issue order, and every beat's error status judged from what was sent.
  task automatic run(input logic [31:0] sa, input logic [31:0] st, input int nreq,
                     input int len, input int ar_prob, input int r_prob,
                     input int err_prob, input int hold);
    int          k;
    int          ncomp;
    int          b;
    int          cyc;
    int          q[$];
    logic [31:0] exp_addr;
    logic [3:0]  fid;
    logic        ar_hs;
    logic        e;
    logic        finished;

    @(negedge clk);
    start      = 1'b1;
    start_addr = sa;
    stride     = st;
    num_req    = 16'(nreq);
    len_cfg    = 4'(len);
    @(negedge clk);
    start    = 1'b0;
    m_beats  = '0;
    m_err    = 0;
    m_xor    = '0;
    k        = 0;
    ncomp    = 0;
    b        = 0;
    cyc      = 0;
    finished = 1'b0;
    q.delete();

    while (!finished && cyc < 5000) begin
      check("arvalid", 128'(arvalid), 128'((k < nreq) && ((k - ncomp) < 4)));
      check("rready", 128'(rready), 128'(1'b1));
      if (arvalid) begin
        exp_addr = sa + st * 32'(k);
        check("araddr", 128'(araddr), 128'(exp_addr));
        check("arid", 128'(arid), 128'(k % 16));
        check("arlen", 128'(arlen), 128'(len));
        check("arsize", 128'(arsize), 128'(3'd4));
        check("arburst", 128'(arburst), 128'(2'b01));
      end

      arready = ($urandom_range(99) < 32'(ar_prob));
      ar_hs   = arvalid && arready;

      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = '0; rdata = '0;
      if (cyc >= hold && q.size() > 0 && $urandom_range(99) < 32'(r_prob)) begin
        fid    = 4'(q[0]);
        rvalid = 1'b1;
        rid    = fid;
        rlast  = (b >= len);
        rdata  = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(99) < 32'(err_prob)) begin
          case ($urandom_range(3))
            0: rid = fid ^ 4'h1;
            1: if (b < len) rlast = 1'b1; else rresp = 2'b10;
            2: if (b == len) rlast = 1'b0; else rresp = 2'b11;
            default: rresp = 2'($urandom_range(3, 1));
          endcase
        end
        e = (rresp != 2'b00) || (rid != fid) || (rlast != (b == len));
        m_beats = m_beats + 32'd1;
        m_xor   = m_xor ^ rdata;
        if (e && m_err < 65535) m_err++;
        if (rlast) begin
          void'(q.pop_front());
          ncomp++;
          b = 0;
        end else if (b < 255) begin
          b++;
        end
      end

      // Stray start pulses while busy must be ignored
      start = ($urandom_range(49) == 0);
      if (start) begin
        num_req    = 16'($urandom);
        start_addr = $urandom;
        len_cfg    = 4'($urandom);
      end

      if (ar_hs) begin
        q.push_back(k);
        k++;
      end
      if (k == nreq && q.size() == 0) finished = 1'b1;
      cyc++;
      @(negedge clk);
    end

    check("run_complete", 128'(finished), 128'(1'b1));
    idle_inputs();
    check("busy_last_beat", 128'(busy), 128'(1'b1));
    check("done_last_beat", 128'(done), 128'(1'b0));
    @(negedge clk);
    check("done", 128'(done), 128'(1'b1));
    check("busy_end", 128'(busy), 128'(1'b0));
    check("arvalid_end", 128'(arvalid), 128'(1'b0));
    check("beat_cnt", 128'(beat_cnt), 128'(m_beats));
    check("err_cnt", 128'(err_cnt), 128'(m_err));
    check("rdata_xor", 128'(rdata_xor), m_xor);
  endtask

  task automatic zero_req();
    @(negedge clk);
    start   = 1'b1;
    num_req = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", 128'(done), 128'(1'b1));
    check("zero_busy", 128'(busy), 128'(1'b0));
    check("zero_beat_cnt", 128'(beat_cnt), 128'(0));
    check("zero_err_cnt", 128'(err_cnt), 128'(0));
    check("zero_xor", 128'(rdata_xor), 128'(0));
    repeat (3) begin
      check("zero_arvalid", 128'(arvalid), 128'(1'b0));
      check("zero_rready", 128'(rready), 128'(1'b0));
      @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_arvalid"}, 128'(arvalid), 128'(0));
    check({pfx, "_rready"}, 128'(rready), 128'(0));
    check({pfx, "_arid"}, 128'(arid), 128'(0));
    check({pfx, "_araddr"}, 128'(araddr), 128'(0));
    check({pfx, "_arlen"}, 128'(arlen), 128'(0));
    check({pfx, "_busy"}, 128'(busy), 128'(0));
    check({pfx, "_done"}, 128'(done), 128'(0));
    check({pfx, "_beat_cnt"}, 128'(beat_cnt), 128'(0));
    check({pfx, "_err_cnt"}, 128'(err_cnt), 128'(0));
    check({pfx, "_xor"}, 128'(rdata_xor), 128'(0));
  endtask

  initial begin
    rst_n      = 1'b0;
    start_addr = '0;
    stride     = '0;
    num_req    = '0;
    len_cfg    = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    zero_req();
    run(32'h0000_0000, 32'h40, 4, 3, 100, 100, 0, 0);
    zero_req();
    run(32'h0000_1000, 32'h80, 8, 1, 100, 100, 0, 30);
    run(32'hFFFF_FFC0, 32'h40, 2, 0, 100, 100, 0, 0);
    run(32'h0001_0000, 32'h100, 20, 2, 100, 60, 0, 0);
    run(32'h0000_2000, 32'h10, 6, 3, 40, 100, 0, 8);
    for (int i = 0; i < 12; i++) begin
      run($urandom, $urandom, int'($urandom_range(20, 1)), int'($urandom_range(7)),
          int'($urandom_range(100, 30)), int'($urandom_range(100, 20)),
          (i % 2 == 0) ? 0 : 20, int'($urandom_range(10)));
    end

    // Reset with two bursts in flight and arvalid still high
    @(negedge clk);
    start      = 1'b1;
    start_addr = 32'h0000_1000;
    stride     = 32'h100;
    num_req    = 16'd8;
    len_cfg    = 4'd1;
    arready    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_arvalid", 128'(arvalid), 128'(1'b1));
    check("pre_reset_araddr", 128'(araddr), 128'(32'h0000_1200));
    rst_n   = 1'b0;
    arready = 1'b0;
    rvalid  = 1'b1;
    rid     = 4'd0;
    rdata   = {4{32'hA5A5_5A5A}};
    rlast   = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    run(32'h0000_3000, 32'h40, 5, 2, 80, 80, 10, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
